// File: rtl/reliable_send_flow_match_pkg.sv
// reliable_send_flow_match_pkg: opcodes, status codes, FSM states and the XOR-fold hash shared with the control-plane driver
package reliable_send_flow_match_pkg;
  localparam logic [3:0] OP_INSERT = 4'b0001;
  localparam logic [3:0] OP_DELETE = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b1101;
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_COLLISION = 2'd1;
  localparam logic [1:0] ST_NOT_FOUND = 2'd2;
  localparam logic [1:0] ST_BAD_OP = 2'd3;
  typedef enum logic [2:0] {INIT, IDLE, CFG_RD, CFG_WR, SWEEP, RESP} state_t;
  function automatic logic [31:0] xor_fold(input logic [255:0] key, input int aw);
    logic [255:0] k;
    logic [31:0] mask;
    xor_fold = '0;
    mask = 32'((64'd1 << aw) - 64'd1);
    k = key;
    for (int c = 0; c < 256; c++) begin
      xor_fold ^= k[31:0] & mask;
      k = k >> aw;
    end
  endfunction
endpackage

// File: rtl/reliable_send_flow_table_ram.sv
// reliable_send_flow_table_ram: direct-mapped {valid, key} storage with one gated synchronous read port and one write port
module reliable_send_flow_table_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/reliable_send_flow_match.sv
// reliable_send_flow_match: hashed flow-key lookup with in-order mat/phv streams and cfg port; RELIABLE_FLOW_MATCH_STATS_EN adds hit/miss counters
module reliable_send_flow_match
  import reliable_send_flow_match_pkg::*;
#(
  parameter int PHV_WIDTH = 456,
  parameter int KEY_OFFSET = 0,
  parameter int KEY_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PHV_WIDTH-1:0]    s_phv_info,
  input  logic                    s_phv_valid,
  output logic                    s_phv_ready,
  output logic [PHV_WIDTH-1:0]    m_phv_info,
  output logic                    m_phv_valid,
  input  logic                    m_phv_ready,
  output logic                    m_mat_hit,
  output logic [ADDR_WIDTH-1:0]   m_mat_addr,
  output logic                    m_mat_valid,
  input  logic                    m_mat_ready,
  input  logic [KEY_WIDTH-1:0]    s_cfg_key,
  input  logic [OPCODE_WIDTH-1:0] s_cfg_opcode,
  input  logic                    s_cfg_valid,
  output logic                    s_cfg_ready,
  output logic [1:0]              m_cfg_bstatus,
  output logic [ADDR_WIDTH-1:0]   m_cfg_baddr,
  output logic                    m_cfg_bvalid,
`ifdef RELIABLE_FLOW_MATCH_STATS_EN
  output logic [31:0]             stat_hit_count,
  output logic [31:0]             stat_miss_count,
`endif
  input  logic                    m_cfg_bready
);
  localparam int DW = KEY_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cfg_idx, phv_idx, s1_idx, rd_addr, wr_addr;
  logic [KEY_WIDTH-1:0] cfg_key, s1_key;
  logic [OPCODE_WIDTH-1:0] cfg_op;
  logic [31:0] phv_fold, cfg_fold;
  logic [DW-1:0] rd_data, wr_data;
  logic [PHV_WIDTH-1:0] s1_phv;
  logic [1:0] cfg_status;
  logic rd_en, wr_en, s1_v, adv, phv_acc, cfg_acc, sweeping, ent_hit;
  logic is_ins, in_rw, in_clr, cfg_v, cfg_match, unused_fold;
  assign phv_fold = xor_fold(256'(s_phv_info[KEY_OFFSET +: KEY_WIDTH]), ADDR_WIDTH);
  assign cfg_fold = xor_fold(256'(s_cfg_key), ADDR_WIDTH);
  assign phv_idx = phv_fold[ADDR_WIDTH-1:0];
  assign unused_fold = ^{phv_fold[31:ADDR_WIDTH], cfg_fold[31:ADDR_WIDTH]};
  assign adv = (!m_mat_valid || m_mat_ready) && (!m_phv_valid || m_phv_ready);
  assign s_cfg_ready = state == IDLE && !s1_v;
  assign cfg_acc = s_cfg_valid && s_cfg_ready;
  assign s_phv_ready = state == IDLE && !s_cfg_valid && !(s1_v && !adv);
  assign phv_acc = s_phv_valid && s_phv_ready;
  assign sweeping = state == INIT || state == SWEEP;
  assign in_rw = s_cfg_opcode == OPCODE_WIDTH'(OP_INSERT) || s_cfg_opcode == OPCODE_WIDTH'(OP_DELETE);
  assign in_clr = s_cfg_opcode == OPCODE_WIDTH'(OP_CLEAR);
  assign is_ins = cfg_op == OPCODE_WIDTH'(OP_INSERT);
  assign cfg_v = rd_data[KEY_WIDTH];
  assign cfg_match = cfg_v && rd_data[KEY_WIDTH-1:0] == cfg_key;
  assign cfg_status = is_ins ? (!cfg_v || cfg_match ? ST_OK : ST_COLLISION) : (cfg_match ? ST_OK : ST_NOT_FOUND);
  assign s1_key = s1_phv[KEY_OFFSET +: KEY_WIDTH];
  assign ent_hit = rd_data[KEY_WIDTH] && rd_data[KEY_WIDTH-1:0] == s1_key;
  assign rd_en = phv_acc || state == CFG_RD;
  assign rd_addr = state == CFG_RD ? cfg_idx : phv_idx;
  assign wr_en = sweeping || (state == CFG_WR && (is_ins ? !cfg_v : cfg_match));
  assign wr_addr = sweeping ? cnt : cfg_idx;
  assign wr_data = sweeping ? '0 : {is_ins, cfg_key};
  assign m_cfg_bvalid = state == RESP;
  reliable_send_flow_table_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DW)) table_ram (
    .clk(clk),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );
  always_comb begin
    state_n = state;
    case (state)
      INIT:    state_n = cnt == LAST ? IDLE : INIT;
      IDLE:    state_n = !cfg_acc ? IDLE : in_rw ? CFG_RD : in_clr ? SWEEP : RESP;
      CFG_RD:  state_n = CFG_WR;
      CFG_WR:  state_n = RESP;
      SWEEP:   state_n = cnt == LAST ? RESP : SWEEP;
      RESP:    state_n = m_cfg_bready ? IDLE : RESP;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      cfg_key <= '0;
      cfg_op <= '0;
      cfg_idx <= '0;
      m_cfg_bstatus <= ST_OK;
      m_cfg_baddr <= '0;
    end else begin
      state <= state_n;
      cnt <= sweeping ? cnt + ADDR_WIDTH'(1) : '0;
      if (cfg_acc) begin
        cfg_key <= s_cfg_key;
        cfg_op <= s_cfg_opcode;
        cfg_idx <= cfg_fold[ADDR_WIDTH-1:0];
        m_cfg_bstatus <= in_clr ? ST_OK : ST_BAD_OP;
        m_cfg_baddr <= '0;
      end
      if (state == CFG_WR) begin
        m_cfg_bstatus <= cfg_status;
        m_cfg_baddr <= cfg_idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_phv <= '0;
      s1_idx <= '0;
      m_mat_valid <= 1'b0;
      m_phv_valid <= 1'b0;
      m_mat_hit <= 1'b0;
      m_mat_addr <= '0;
      m_phv_info <= '0;
    end else begin
      if (!s1_v || adv) s1_v <= phv_acc;
      if (phv_acc) begin
        s1_phv <= s_phv_info;
        s1_idx <= phv_idx;
      end
      if (adv) begin
        m_mat_valid <= s1_v;
        m_phv_valid <= s1_v;
        if (s1_v) begin
          m_mat_hit <= ent_hit;
          m_mat_addr <= s1_idx;
          m_phv_info <= s1_phv;
        end
      end else begin
        if (m_mat_ready) m_mat_valid <= 1'b0;
        if (m_phv_ready) m_phv_valid <= 1'b0;
      end
    end
  end
`ifdef RELIABLE_FLOW_MATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || state == SWEEP) begin
      stat_hit_count <= '0;
      stat_miss_count <= '0;
    end else if (m_mat_valid && m_mat_ready) begin
      if (m_mat_hit && stat_hit_count != '1) stat_hit_count <= stat_hit_count + 32'd1;
      if (!m_mat_hit && stat_miss_count != '1) stat_miss_count <= stat_miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_reliable_send_flow_match.sv
// tb_reliable_send_flow_match: directed and randomized lookups/control ops checked against an associative-array table model
module tb_reliable_send_flow_match;
  localparam int PW = 456;
  localparam int KW = 32;
  localparam int AW = 10;
  localparam int OW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PW-1:0] s_phv_info = '0;
  logic s_phv_valid = 1'b0;
  logic s_phv_ready;
  logic [PW-1:0] m_phv_info;
  logic m_phv_valid;
  logic m_phv_ready = 1'b1;
  logic m_mat_hit;
  logic [AW-1:0] m_mat_addr;
  logic m_mat_valid;
  logic m_mat_ready = 1'b1;
  logic [KW-1:0] s_cfg_key = '0;
  logic [OW-1:0] s_cfg_opcode = '0;
  logic s_cfg_valid = 1'b0;
  logic s_cfg_ready;
  logic [1:0] m_cfg_bstatus;
  logic [AW-1:0] m_cfg_baddr;
  logic m_cfg_bvalid;
  logic m_cfg_bready = 1'b1;
`ifdef RELIABLE_FLOW_MATCH_STATS_EN
  logic [31:0] stat_hit_count, stat_miss_count;
`endif
  int checks = 0;
  int errors = 0;
  int bad_acc = 0;
  int hits = 0;
  int misses = 0;
  bit rnd = 1'b0;
  bit in_cfg = 1'b0;
  bit [KW-1:0] tbl [int];
  bit [KW-1:0] keys [6];
  logic [AW:0] exp_mat[$], got_mat[$];
  logic [PW-1:0] exp_phv[$], got_phv[$];

  always #5 clk = ~clk;

  reliable_send_flow_match dut (
    .clk(clk),
    .rst(rst),
    .s_phv_info(s_phv_info),
    .s_phv_valid(s_phv_valid),
    .s_phv_ready(s_phv_ready),
    .m_phv_info(m_phv_info),
    .m_phv_valid(m_phv_valid),
    .m_phv_ready(m_phv_ready),
    .m_mat_hit(m_mat_hit),
    .m_mat_addr(m_mat_addr),
    .m_mat_valid(m_mat_valid),
    .m_mat_ready(m_mat_ready),
    .s_cfg_key(s_cfg_key),
    .s_cfg_opcode(s_cfg_opcode),
    .s_cfg_valid(s_cfg_valid),
    .s_cfg_ready(s_cfg_ready),
    .m_cfg_bstatus(m_cfg_bstatus),
    .m_cfg_baddr(m_cfg_baddr),
    .m_cfg_bvalid(m_cfg_bvalid),
`ifdef RELIABLE_FLOW_MATCH_STATS_EN
    .stat_hit_count(stat_hit_count),
    .stat_miss_count(stat_miss_count),
`endif
    .m_cfg_bready(m_cfg_bready)
  );

  always @(negedge clk) begin
    if (m_mat_valid && m_mat_ready) got_mat.push_back({m_mat_hit, m_mat_addr});
    if (m_phv_valid && m_phv_ready) got_phv.push_back(m_phv_info);
    if (in_cfg && s_phv_valid && s_phv_ready) bad_acc++;
  end

  task automatic chk(input string tag, input logic [PW+7:0] obs, input logic [PW+7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fold(input bit [KW-1:0] k);
    int r = 0;
    for (int b = 0; b < KW; b++) if (k[b]) r ^= 1 << (b % AW);
    return r;
  endfunction

  function automatic int model_cfg(input bit [3:0] op, input bit [KW-1:0] k);
    int i = fold(k);
    if (op == 4'b0001) begin
      if (!tbl.exists(i)) begin
        tbl[i] = k;
        return 0;
      end
      return tbl[i] == k ? 0 : 1;
    end
    if (op == 4'b0010) begin
      if (tbl.exists(i) && tbl[i] == k) begin
        tbl.delete(i);
        return 0;
      end
      return 2;
    end
    if (op == 4'b1101) begin
      tbl.delete();
      return 0;
    end
    return 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    m_mat_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_phv_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic send_phv(input bit [KW-1:0] k);
    logic [PW-1:0] p;
    int n = 0;
    int i;
    bit acc = 1'b0;
    bit h;
    for (int b = 0; b < PW; b++) p[b] = 1'($urandom);
    p[KW-1:0] = k;
    s_phv_info = p;
    s_phv_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_phv_ready;
      if (acc) begin
        i = fold(k);
        h = tbl.exists(i) && tbl[i] == k;
        if (h) hits++;
        else misses++;
        exp_mat.push_back({h, AW'(i)});
        exp_phv.push_back(p);
      end
      tick();
      n++;
    end
    s_phv_valid = 1'b0;
    chk("phv_accept", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((got_mat.size() < exp_mat.size() || got_phv.size() < exp_phv.size()) && n < 1000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("mat_beat_count", got_mat.size(), exp_mat.size());
    chk("phv_beat_count", got_phv.size(), exp_phv.size());
    while (exp_mat.size() > 0 && got_mat.size() > 0) chk("mat_beat", got_mat.pop_front(), exp_mat.pop_front());
    while (exp_phv.size() > 0 && got_phv.size() > 0) chk("phv_beat", got_phv.pop_front(), exp_phv.pop_front());
    exp_mat.delete();
    got_mat.delete();
    exp_phv.delete();
    got_phv.delete();
  endtask

  task automatic lookup_lat(input bit [KW-1:0] k);
    int lat = 1;
    send_phv(k);
    while (lat < 10) begin
      @(negedge clk);
      if (m_mat_valid) break;
      tick();
      lat++;
    end
    chk("lookup_latency", lat, 2);
    chk("phv_with_mat", m_phv_valid, 1);
    tick();
    drain();
  endtask

  task automatic cfg(input bit [3:0] op, input bit [KW-1:0] k, input int exp_lat, input bit hold);
    int n = 0;
    int lat = 1;
    int exp_st;
    int exp_ad;
    bit acc = 1'b0;
    in_cfg = 1'b1;
    s_cfg_valid = 1'b1;
    s_cfg_opcode = op;
    s_cfg_key = k;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_cfg_ready;
      tick();
      n++;
    end
    s_cfg_valid = 1'b0;
    chk("cfg_accept", acc, 1);
    exp_st = model_cfg(op, k);
    exp_ad = (op == 4'b0001 || op == 4'b0010) ? fold(k) : 0;
    while (lat < 3000) begin
      @(negedge clk);
      if (m_cfg_bvalid) break;
      tick();
      lat++;
    end
    in_cfg = 1'b0;
    s_phv_valid = 1'b0;
    chk("cfg_latency", lat, exp_lat);
    chk("cfg_status", m_cfg_bstatus, exp_st);
    chk("cfg_baddr", m_cfg_baddr, exp_ad);
    if (hold) begin
      m_cfg_bready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("bvalid_hold", {m_cfg_bvalid, m_cfg_bstatus}, {1'b1, 2'(exp_st)});
      m_cfg_bready = 1'b1;
    end
    tick();
    @(negedge clk);
    chk("bvalid_drop", m_cfg_bvalid, 0);
    tick();
  endtask

  initial begin
    int n = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctrl", {s_phv_ready, s_cfg_ready, m_mat_valid, m_phv_valid, m_cfg_bvalid, m_mat_hit, m_mat_addr, m_cfg_bstatus, m_cfg_baddr}, 0);
    chk("reset_phv", m_phv_info, 0);
    rst = 1'b0;
    while (!s_cfg_ready && n < 3000) begin
      tick();
      n++;
    end
    chk("init_sweep_len", n, 1024);
    chk("idle_ready", {s_cfg_ready, s_phv_ready}, 2'b11);
    cfg(4'b0001, 32'h0000_1234, 3, 1'b0);
    lookup_lat(32'h0000_1234);
    cfg(4'b0001, 32'h0000_1234, 3, 1'b0);
    cfg(4'b0001, 32'h0000_1635, 3, 1'b0);
    lookup_lat(32'h0000_1635);
    cfg(4'b0111, $urandom, 1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      keys[i] = $urandom;
      cfg(4'b0001, keys[i], 3, 1'b0);
    end
    rnd = 1'b1;
    for (int i = 0; i < 24; i++) send_phv($urandom_range(0, 1) != 0 ? keys[$urandom_range(0, 5)] : KW'($urandom));
    drain();
    rnd = 1'b0;
    cfg(4'b0010, 32'hDEAD_BEEF, 3, 1'b0);
    cfg(4'b0010, 32'h0000_1234, 3, 1'b0);
    lookup_lat(32'h0000_1234);
    rnd = 1'b1;
    for (int i = 0; i < 5; i++) send_phv(keys[i]);
    s_phv_info = PW'(keys[5]);
    s_phv_valid = 1'b1;
    cfg(4'b1101, 32'h0, 1025, 1'b0);
    hits = 0;
    misses = 0;
    chk("phv_blocked_in_cfg", bad_acc, 0);
`ifdef RELIABLE_FLOW_MATCH_STATS_EN
    chk("stats_cleared", {stat_hit_count, stat_miss_count}, 0);
`endif
    drain();
    for (int i = 0; i < 6; i++) send_phv(keys[i]);
    send_phv(32'h0000_1635);
    drain();
    rnd = 1'b0;
    cfg(4'b0001, keys[0], 3, 1'b0);
    cfg(4'b0001, keys[1], 3, 1'b0);
    send_phv(keys[0]);
    send_phv(keys[1]);
    send_phv(keys[0]);
    send_phv(32'h0000_1234);
    drain();
`ifdef RELIABLE_FLOW_MATCH_STATS_EN
    chk("stat_hits", stat_hit_count, hits);
    chk("stat_misses", stat_miss_count, misses);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
